// File: rtl/mmio_arb_pkg.sv
// Shared types and widths for the two-master MMIO AXI4 arbiter.
// Holds FSM state enums, master index type and AXI field widths.
package mmio_arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int STRB_W  = DATA_W / 8;
  localparam int ID_W    = 5;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  typedef enum logic {
    MST_S0 = 1'b0,
    MST_S1 = 1'b1
  } mst_t;

endpackage

// File: rtl/mmio_axi_arbiter_if.sv
// AXI4 bundle (aw/w/b/ar/r, full field set) for the MMIO arbiter.
// master modport drives requests; slave modport drives responses.
interface mmio_axi_arbiter_if;
  import mmio_arb_pkg::*;

  logic [ID_W-1:0]    awid;
  logic [ADDR_W-1:0]  awaddr;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic               awlock;
  logic [CACHE_W-1:0] awcache;
  logic [PROT_W-1:0]  awprot;
  logic [QOS_W-1:0]   awqos;
  logic               awvalid;
  logic               awready;

  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;

  logic [ID_W-1:0]    bid;
  logic [RESP_W-1:0]  bresp;
  logic               bvalid;
  logic               bready;

  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arlock;
  logic [CACHE_W-1:0] arcache;
  logic [PROT_W-1:0]  arprot;
  logic [QOS_W-1:0]   arqos;
  logic               arvalid;
  logic               arready;

  logic [ID_W-1:0]    rid;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/mmio_arb_picker.sv
// 2-way grant picker: req[1:0] -> pick; upd/upd_idx record the last grant.
// MMIO_ARB_FIXED_PRIO_EN: S0 always wins, no last-grant register.
module mmio_arb_picker
  import mmio_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  mst_t       upd_idx,
  output mst_t       pick
);

`ifdef MMIO_ARB_FIXED_PRIO_EN

  logic unused_pick_in;
  assign unused_pick_in = ^{clk, reset, upd, upd_idx};

  assign pick = (req == 2'b10) ? MST_S1 : MST_S0;

`else

  mst_t last;

  // Resets to S1 so S0 takes the first contested grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= MST_S1;
    end else if (upd) begin
      last <= upd_idx;
    end
  end

  always_comb begin
    pick = MST_S0;
    unique case (1'b1)
      (req == 2'b11):
        pick = (last == MST_S0) ? MST_S1 : MST_S0;
      (req == 2'b10):
        pick = MST_S1;
      default:
        pick = MST_S0;
    endcase
  end

`endif

endmodule

// File: rtl/mmio_axi_arbiter.sv
// Two-master (s0, s1) to one-slave (m) AXI4 MMIO arbiter; clk, reset.
// Independent rd/wr FSMs, one outstanding each; see MMIO_ARB_FIXED_PRIO_EN.
module mmio_axi_arbiter
  import mmio_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mmio_axi_arbiter_if.slave   s0,
  mmio_axi_arbiter_if.slave   s1,
  mmio_axi_arbiter_if.master  m
);

  wr_state_t wr_st, wr_nx;
  rd_state_t rd_st, rd_nx;
  mst_t      wgrant, wgrant_nx, wpick;
  mst_t      rgrant, rgrant_nx, rpick;

  logic aw_en, w_en, b_en;
  logic ar_en, r_en;
  logic ws, rs;
  logic b_done, r_done;

  assign ws = (wgrant == MST_S1);
  assign rs = (rgrant == MST_S1);

  assign b_done = b_en & m.bvalid & m.bready;
  assign r_done = r_en & m.rvalid & m.rready & m.rlast;

  mmio_arb_picker u_wpick (
    .clk     (clk),
    .reset   (reset),
    .req     ({s1.awvalid, s0.awvalid}),
    .upd     (b_done),
    .upd_idx (wgrant),
    .pick    (wpick)
  );

  mmio_arb_picker u_rpick (
    .clk     (clk),
    .reset   (reset),
    .req     ({s1.arvalid, s0.arvalid}),
    .upd     (r_done),
    .upd_idx (rgrant),
    .pick    (rpick)
  );

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_st  <= WR_IDLE;
      wgrant <= MST_S0;
    end else begin
      wr_st  <= wr_nx;
      wgrant <= wgrant_nx;
    end
  end

  always_comb begin
    wr_nx     = wr_st;
    wgrant_nx = wgrant;
    unique case (wr_st)
      WR_IDLE: begin
        if (s0.awvalid | s1.awvalid) begin
          wr_nx     = WR_ADDR;
          wgrant_nx = wpick;
        end
      end
      WR_ADDR: begin
        if (m.awvalid & m.awready) wr_nx = WR_DATA;
      end
      WR_DATA: begin
        if (m.wvalid & m.wready & m.wlast)
          wr_nx = WR_RESP;
      end
      WR_RESP: begin
        if (m.bvalid & m.bready) wr_nx = WR_IDLE;
      end
      default: wr_nx = WR_IDLE;
    endcase
  end

  always_comb begin
    aw_en = 1'b0;
    w_en  = 1'b0;
    b_en  = 1'b0;
    unique case (wr_st)
      WR_ADDR: aw_en = 1'b1;
      WR_DATA: w_en  = 1'b1;
      WR_RESP: b_en  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_st  <= RD_IDLE;
      rgrant <= MST_S0;
    end else begin
      rd_st  <= rd_nx;
      rgrant <= rgrant_nx;
    end
  end

  always_comb begin
    rd_nx     = rd_st;
    rgrant_nx = rgrant;
    unique case (rd_st)
      RD_IDLE: begin
        if (s0.arvalid | s1.arvalid) begin
          rd_nx     = RD_ADDR;
          rgrant_nx = rpick;
        end
      end
      RD_ADDR: begin
        if (m.arvalid & m.arready) rd_nx = RD_DATA;
      end
      RD_DATA: begin
        if (m.rvalid & m.rready & m.rlast)
          rd_nx = RD_IDLE;
      end
      default: rd_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    ar_en = 1'b0;
    r_en  = 1'b0;
    unique case (rd_st)
      RD_ADDR: ar_en = 1'b1;
      RD_DATA: r_en  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- AW / W / B routing ----------------
  assign m.awid    = ws ? s1.awid    : s0.awid;
  assign m.awaddr  = ws ? s1.awaddr  : s0.awaddr;
  assign m.awlen   = ws ? s1.awlen   : s0.awlen;
  assign m.awsize  = ws ? s1.awsize  : s0.awsize;
  assign m.awburst = ws ? s1.awburst : s0.awburst;
  assign m.awlock  = ws ? s1.awlock  : s0.awlock;
  assign m.awcache = ws ? s1.awcache : s0.awcache;
  assign m.awprot  = ws ? s1.awprot  : s0.awprot;
  assign m.awqos   = ws ? s1.awqos   : s0.awqos;
  assign m.awvalid =
    aw_en & (ws ? s1.awvalid : s0.awvalid);
  assign s0.awready = aw_en & ~ws & m.awready;
  assign s1.awready = aw_en &  ws & m.awready;

  // W is held off until the AW handshake has moved us to WR_DATA.
  assign m.wdata  = ws ? s1.wdata : s0.wdata;
  assign m.wstrb  = ws ? s1.wstrb : s0.wstrb;
  assign m.wlast  = ws ? s1.wlast : s0.wlast;
  assign m.wvalid =
    w_en & (ws ? s1.wvalid : s0.wvalid);
  assign s0.wready = w_en & ~ws & m.wready;
  assign s1.wready = w_en &  ws & m.wready;

  // B goes back by held grant; bid is not decoded.
  assign s0.bid    = m.bid;
  assign s0.bresp  = m.bresp;
  assign s1.bid    = m.bid;
  assign s1.bresp  = m.bresp;
  assign s0.bvalid = b_en & ~ws & m.bvalid;
  assign s1.bvalid = b_en &  ws & m.bvalid;
  assign m.bready  =
    b_en & (ws ? s1.bready : s0.bready);

  // ---------------- AR / R routing ----------------
  assign m.arid    = rs ? s1.arid    : s0.arid;
  assign m.araddr  = rs ? s1.araddr  : s0.araddr;
  assign m.arlen   = rs ? s1.arlen   : s0.arlen;
  assign m.arsize  = rs ? s1.arsize  : s0.arsize;
  assign m.arburst = rs ? s1.arburst : s0.arburst;
  assign m.arlock  = rs ? s1.arlock  : s0.arlock;
  assign m.arcache = rs ? s1.arcache : s0.arcache;
  assign m.arprot  = rs ? s1.arprot  : s0.arprot;
  assign m.arqos   = rs ? s1.arqos   : s0.arqos;
  assign m.arvalid =
    ar_en & (rs ? s1.arvalid : s0.arvalid);
  assign s0.arready = ar_en & ~rs & m.arready;
  assign s1.arready = ar_en &  rs & m.arready;

  assign s0.rid    = m.rid;
  assign s0.rdata  = m.rdata;
  assign s0.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rid    = m.rid;
  assign s1.rdata  = m.rdata;
  assign s1.rresp  = m.rresp;
  assign s1.rlast  = m.rlast;
  assign s0.rvalid = r_en & ~rs & m.rvalid;
  assign s1.rvalid = r_en &  rs & m.rvalid;
  assign m.rready  =
    r_en & (rs ? s1.rready : s0.rready);

endmodule

// File: tb/tb_mmio_axi_arbiter.sv
// Directed self-checking bench for mmio_axi_arbiter.
// Drives both masters and plays the downstream slave by hand.
module tb_mmio_axi_arbiter;
  import mmio_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mmio_axi_arbiter_if s0_if ();
  mmio_axi_arbiter_if s1_if ();
  mmio_axi_arbiter_if m_if ();

  mmio_axi_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .s0    (s0_if),
    .s1    (s1_if),
    .m     (m_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] hs_out();
    return {s0_if.awready, s0_if.wready,
            s0_if.bvalid, s0_if.arready,
            s0_if.rvalid,
            s1_if.awready, s1_if.wready,
            s1_if.bvalid, s1_if.arready,
            s1_if.rvalid,
            m_if.awvalid, m_if.wvalid,
            m_if.bready, m_if.arvalid,
            m_if.rready};
  endfunction

  task automatic clr();
    s0_if.awid = '0; s0_if.awaddr = '0;
    s0_if.awlen = '0; s0_if.awsize = '0;
    s0_if.awburst = '0; s0_if.awlock = 1'b0;
    s0_if.awcache = '0; s0_if.awprot = '0;
    s0_if.awqos = '0; s0_if.awvalid = 1'b0;
    s0_if.wdata = '0; s0_if.wstrb = '0;
    s0_if.wlast = 1'b0; s0_if.wvalid = 1'b0;
    s0_if.bready = 1'b0;
    s0_if.arid = '0; s0_if.araddr = '0;
    s0_if.arlen = '0; s0_if.arsize = '0;
    s0_if.arburst = '0; s0_if.arlock = 1'b0;
    s0_if.arcache = '0; s0_if.arprot = '0;
    s0_if.arqos = '0; s0_if.arvalid = 1'b0;
    s0_if.rready = 1'b0;
    s1_if.awid = '0; s1_if.awaddr = '0;
    s1_if.awlen = '0; s1_if.awsize = '0;
    s1_if.awburst = '0; s1_if.awlock = 1'b0;
    s1_if.awcache = '0; s1_if.awprot = '0;
    s1_if.awqos = '0; s1_if.awvalid = 1'b0;
    s1_if.wdata = '0; s1_if.wstrb = '0;
    s1_if.wlast = 1'b0; s1_if.wvalid = 1'b0;
    s1_if.bready = 1'b0;
    s1_if.arid = '0; s1_if.araddr = '0;
    s1_if.arlen = '0; s1_if.arsize = '0;
    s1_if.arburst = '0; s1_if.arlock = 1'b0;
    s1_if.arcache = '0; s1_if.arprot = '0;
    s1_if.arqos = '0; s1_if.arvalid = 1'b0;
    s1_if.rready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bid = '0; m_if.bresp = '0;
    m_if.bvalid = 1'b0; m_if.arready = 1'b0;
    m_if.rid = '0; m_if.rdata = '0;
    m_if.rresp = '0; m_if.rlast = 1'b0;
    m_if.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr();
    s0_if.awvalid = 1'b1;
    s1_if.arvalid = 1'b1;
    m_if.awready = 1'b1;
    m_if.rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (hs_out() !== 15'd0) begin
      errors++;
      $display("FAIL reset_hs: got %h want 0",
               hs_out());
    end
    checks++;
    if (dut.wr_st !== WR_IDLE ||
        dut.rd_st !== RD_IDLE) begin
      errors++;
      $display("FAIL reset_fsm: got %0d/%0d want 0/0",
               dut.wr_st, dut.rd_st);
    end
    checks++;
    if (dut.wgrant !== MST_S0 ||
        dut.rgrant !== MST_S0) begin
      errors++;
      $display("FAIL reset_grant: got %b%b want 00",
               dut.wgrant, dut.rgrant);
    end
    clr();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    logic [2:0] s1x;
    s1x = '0;
    @(negedge clk);
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    s0_if.awvalid = 1'b1;
    s0_if.awid = 5'd2;
    s0_if.awaddr = 32'h6000_0000;
    s0_if.awlen = 8'd0;
    s0_if.awsize = 3'd3;
    s0_if.awburst = 2'd1;
    s0_if.wvalid = 1'b1;
    s0_if.wdata = 64'h1122_3344_5566_7788;
    s0_if.wstrb = 8'hFF;
    s0_if.wlast = 1'b1;
    s0_if.bready = 1'b1;
    s1_if.bready = 1'b1;
    #1;
    s1x |= {s1_if.awready, s1_if.wready, s1_if.arready};
    checks++;
    if (m_if.awvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_lat0: got %b want 0",
               m_if.awvalid);
    end
    @(negedge clk);
    #1;
    s1x |= {s1_if.awready, s1_if.wready, s1_if.arready};
    checks++;
    if ({m_if.awvalid, s0_if.awready,
         m_if.awaddr} !== {2'b11, 32'h6000_0000}) begin
      errors++;
      $display("FAIL wr_aw: got %b%b %h want 11 60000000",
               m_if.awvalid, s0_if.awready, m_if.awaddr);
    end
    checks++;
    if ({m_if.awid, m_if.awlen, m_if.awsize,
         m_if.awburst} !== {5'd2, 8'd0, 3'd3, 2'd1}) begin
      errors++;
      $display("FAIL wr_aw_fields: got %h %h %h %h",
               m_if.awid, m_if.awlen, m_if.awsize,
               m_if.awburst);
    end
    checks++;
    if (s0_if.wready !== 1'b0) begin
      errors++;
      $display("FAIL wr_w_early: got %b want 0",
               s0_if.wready);
    end
    @(negedge clk);
    s0_if.awvalid = 1'b0;
    #1;
    s1x |= {s1_if.awready, s1_if.wready, s1_if.arready};
    checks++;
    if ({m_if.wvalid, s0_if.wready, m_if.wdata,
         m_if.wstrb, m_if.wlast} !==
        {2'b11, 64'h1122_3344_5566_7788,
         8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL wr_w: got %b%b %h %h want 11 1122334455667788 ff",
               m_if.wvalid, s0_if.wready, m_if.wdata,
               m_if.wstrb);
    end
    @(negedge clk);
    s0_if.wvalid = 1'b0;
    m_if.bvalid = 1'b1;
    m_if.bid = 5'd2;
    m_if.bresp = 2'b00;
    #1;
    s1x |= {s1_if.awready, s1_if.wready, s1_if.arready};
    checks++;
    if ({s0_if.bvalid, s0_if.bid, s0_if.bresp,
         m_if.bready, s1_if.bvalid} !==
        {1'b1, 5'd2, 2'b00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wr_b: got v%b id%h r%b br%b s1v%b",
               s0_if.bvalid, s0_if.bid, s0_if.bresp,
               m_if.bready, s1_if.bvalid);
    end
    @(negedge clk);
    m_if.bvalid = 1'b0;
    #1;
    checks++;
    if (dut.wr_st !== WR_IDLE ||
        m_if.awvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: got st%0d awv%b want 0 0",
               dut.wr_st, m_if.awvalid);
    end
    checks++;
    if (s1x !== 3'b000) begin
      errors++;
      $display("FAIL wr_s1_quiet: got %b want 000", s1x);
    end
    clr();
  endtask

  task automatic test_rr_read();
    int g;
    @(negedge clk);
    m_if.arready = 1'b1;
    s0_if.rready = 1'b1;
    s1_if.rready = 1'b1;
    s0_if.arvalid = 1'b1;
    s0_if.arid = 5'd3;
    s0_if.araddr = 32'h6000_0100;
    s1_if.arvalid = 1'b1;
    s1_if.arid = 5'd7;
    s1_if.araddr = 32'h6000_0200;
    for (int k = 0; k < 4; k++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      @(negedge clk);
      #1;
      checks++;
      if ({m_if.arvalid, m_if.arid} !==
          {1'b1, (g == 1) ? 5'd7 : 5'd3}) begin
        errors++;
        $display("FAIL rr_ar%0d: got v%b id%0d want v1 id%0d",
                 k, m_if.arvalid, m_if.arid,
                 (g == 1) ? 7 : 3);
      end
      checks++;
      if ({s1_if.arready, s0_if.arready} !==
          ((g == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_arready%0d: got %b%b",
                 k, s1_if.arready, s0_if.arready);
      end
      @(negedge clk);
      if (k == 3) begin
        s0_if.arvalid = 1'b0;
        s1_if.arvalid = 1'b0;
      end
      m_if.rvalid = 1'b1;
      m_if.rlast = 1'b1;
      m_if.rresp = 2'b00;
      m_if.rid = (g == 1) ? 5'd7 : 5'd3;
      m_if.rdata = 64'hD0 + 64'(k);
      #1;
      checks++;
      if ({s1_if.rvalid, s0_if.rvalid,
           (g == 1) ? s1_if.rdata : s0_if.rdata} !==
          {((g == 1) ? 2'b10 : 2'b01),
           64'hD0 + 64'(k)}) begin
        errors++;
        $display("FAIL rr_r%0d: got %b%b %h",
                 k, s1_if.rvalid, s0_if.rvalid,
                 m_if.rdata);
      end
      @(negedge clk);
      m_if.rvalid = 1'b0;
      m_if.rlast = 1'b0;
      #1;
      checks++;
      if (dut.rd_st !== RD_IDLE ||
          m_if.arvalid !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: got st%0d arv%b want 0 0",
                 k, dut.rd_st, m_if.arvalid);
      end
    end
    clr();
  endtask

  task automatic test_burst_read();
    logic [72:0] exp_r;
    logic        gapbad;
    int          beats;
    gapbad = 1'b0;
    beats = 0;
    @(negedge clk);
    m_if.arready = 1'b1;
    s0_if.rready = 1'b1;
    s1_if.rready = 1'b1;
    s1_if.arvalid = 1'b1;
    s1_if.arid = 5'd9;
    s1_if.araddr = 32'h6000_1000;
    s1_if.arlen = 8'd3;
    s1_if.arsize = 3'd3;
    s1_if.arburst = 2'd1;
    @(negedge clk);
    #1;
    checks++;
    if ({m_if.arvalid, m_if.arid, m_if.arlen,
         m_if.arsize, m_if.arburst} !==
        {1'b1, 5'd9, 8'd3, 3'd3, 2'd1}) begin
      errors++;
      $display("FAIL burst_ar: got v%b id%0d len%0d",
               m_if.arvalid, m_if.arid, m_if.arlen);
    end
    @(negedge clk);
    s1_if.arvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int gp = 0; gp < 2; gp++) begin
        m_if.rvalid = 1'b0;
        m_if.rlast = 1'b0;
        #1;
        if (s1_if.rvalid !== 1'b0 ||
            dut.rd_st !== RD_DATA)
          gapbad = 1'b1;
        @(negedge clk);
      end
      m_if.rvalid = 1'b1;
      m_if.rid = 5'd9;
      m_if.rdata = 64'hA0 + 64'(b);
      m_if.rlast = (b == 3);
      m_if.rresp = (b == 3) ? 2'b11 : 2'b00;
      #1;
      exp_r = {1'b1, 5'd9, 64'hA0 + 64'(b),
               (b == 3), (b == 3) ? 2'b11 : 2'b00};
      checks++;
      if ({s1_if.rvalid, s1_if.rid, s1_if.rdata,
           s1_if.rlast, s1_if.rresp} !== exp_r) begin
        errors++;
        $display("FAIL burst_beat%0d: got v%b id%0d %h l%b r%b",
                 b, s1_if.rvalid, s1_if.rid, s1_if.rdata,
                 s1_if.rlast, s1_if.rresp);
      end
      if (s0_if.rvalid !== 1'b0) gapbad = 1'b1;
      if (s1_if.rvalid === 1'b1 &&
          m_if.rready === 1'b1)
        beats++;
      @(negedge clk);
    end
    m_if.rvalid = 1'b0;
    m_if.rlast = 1'b0;
    #1;
    checks++;
    if (dut.rd_st !== RD_IDLE) begin
      errors++;
      $display("FAIL burst_exit: got st%0d want 0",
               dut.rd_st);
    end
    checks++;
    if (beats !== 4) begin
      errors++;
      $display("FAIL burst_count: got %0d want 4", beats);
    end
    checks++;
    if (gapbad !== 1'b0) begin
      errors++;
      $display("FAIL burst_gap: got %b want 0", gapbad);
    end
    clr();
  endtask

  task automatic test_concurrent();
    logic wearly;
    wearly = 1'b0;
    @(negedge clk);
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    m_if.arready = 1'b1;
    s0_if.wvalid = 1'b1;
    s0_if.wdata = 64'hCAFE_F00D_0000_0001;
    s0_if.wstrb = 8'h0F;
    s0_if.wlast = 1'b1;
    s0_if.bready = 1'b1;
    s0_if.rready = 1'b1;
    s1_if.arvalid = 1'b1;
    s1_if.arid = 5'd4;
    s1_if.araddr = 32'h6000_2000;
    s1_if.rready = 1'b1;
    #1;
    wearly |= s0_if.wready;
    @(negedge clk);
    #1;
    wearly |= s0_if.wready;
    checks++;
    if ({m_if.arvalid, m_if.arid} !==
        {1'b1, 5'd4}) begin
      errors++;
      $display("FAIL cc_ar: got v%b id%0d want v1 id4",
               m_if.arvalid, m_if.arid);
    end
    @(negedge clk);
    s1_if.arvalid = 1'b0;
    #1;
    wearly |= s0_if.wready;
    @(negedge clk);
    s0_if.awvalid = 1'b1;
    s0_if.awid = 5'd6;
    s0_if.awaddr = 32'h6000_3000;
    s0_if.awsize = 3'd3;
    #1;
    wearly |= s0_if.wready;
    @(negedge clk);
    #1;
    wearly |= s0_if.wready;
    checks++;
    if ({m_if.awvalid, m_if.awid} !== {1'b1, 5'd6} ||
        dut.rd_st !== RD_DATA) begin
      errors++;
      $display("FAIL cc_aw: got v%b id%0d rd%0d",
               m_if.awvalid, m_if.awid, dut.rd_st);
    end
    @(negedge clk);
    s0_if.awvalid = 1'b0;
    m_if.rvalid = 1'b1;
    m_if.rlast = 1'b1;
    m_if.rid = 5'd4;
    m_if.rdata = 64'h5555;
    #1;
    checks++;
    if ({s0_if.wready, m_if.wvalid, m_if.wdata} !==
        {2'b11, 64'hCAFE_F00D_0000_0001}) begin
      errors++;
      $display("FAIL cc_w: got %b%b %h",
               s0_if.wready, m_if.wvalid, m_if.wdata);
    end
    checks++;
    if ({s1_if.rvalid, s1_if.rid, s1_if.rdata,
         s0_if.rvalid} !==
        {1'b1, 5'd4, 64'h5555, 1'b0}) begin
      errors++;
      $display("FAIL cc_r: got v%b id%0d %h s0v%b",
               s1_if.rvalid, s1_if.rid, s1_if.rdata,
               s0_if.rvalid);
    end
    checks++;
    if (wearly !== 1'b0) begin
      errors++;
      $display("FAIL cc_w_stall: got %b want 0", wearly);
    end
    @(negedge clk);
    s0_if.wvalid = 1'b0;
    m_if.rvalid = 1'b0;
    m_if.rlast = 1'b0;
    m_if.bvalid = 1'b1;
    m_if.bid = 5'd6;
    m_if.bresp = 2'b00;
    #1;
    checks++;
    if ({s0_if.bvalid, s0_if.bid, s0_if.bresp,
         s1_if.bvalid} !== {1'b1, 5'd6, 2'b00, 1'b0} ||
        dut.rd_st !== RD_IDLE) begin
      errors++;
      $display("FAIL cc_b: got v%b id%0d r%b s1v%b rd%0d",
               s0_if.bvalid, s0_if.bid, s0_if.bresp,
               s1_if.bvalid, dut.rd_st);
    end
    @(negedge clk);
    m_if.bvalid = 1'b0;
    #1;
    checks++;
    if (dut.wr_st !== WR_IDLE) begin
      errors++;
      $display("FAIL cc_done: got st%0d want 0",
               dut.wr_st);
    end
    clr();
  endtask

  task automatic test_slverr();
    @(negedge clk);
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    s1_if.awvalid = 1'b1;
    s1_if.awid = 5'h11;
    s1_if.awaddr = 32'h6000_4000;
    s1_if.wvalid = 1'b1;
    s1_if.wdata = 64'hDEAD_BEEF;
    s1_if.wstrb = 8'hFF;
    s1_if.wlast = 1'b1;
    s1_if.bready = 1'b1;
    s0_if.bready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({m_if.awvalid, m_if.awid, s1_if.awready,
         s0_if.awready} !==
        {1'b1, 5'h11, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL se_aw: got v%b id%h r%b%b",
               m_if.awvalid, m_if.awid,
               s1_if.awready, s0_if.awready);
    end
    @(negedge clk);
    s1_if.awvalid = 1'b0;
    @(negedge clk);
    s1_if.wvalid = 1'b0;
    m_if.bvalid = 1'b1;
    m_if.bid = 5'h11;
    m_if.bresp = 2'b10;
    #1;
    checks++;
    if ({s1_if.bvalid, s1_if.bid, s1_if.bresp} !==
        {1'b1, 5'h11, 2'b10}) begin
      errors++;
      $display("FAIL se_b: got v%b id%h r%b want 1 11 10",
               s1_if.bvalid, s1_if.bid, s1_if.bresp);
    end
    checks++;
    if (s0_if.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL se_s0_quiet: got %b want 0",
               s0_if.bvalid);
    end
    @(negedge clk);
    m_if.bvalid = 1'b0;
    #1;
    checks++;
    if (dut.wr_st !== WR_IDLE) begin
      errors++;
      $display("FAIL se_done: got st%0d want 0",
               dut.wr_st);
    end
    clr();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    s0_if.awvalid = 1'b1;
    s0_if.awid = 5'd1;
    s0_if.awaddr = 32'h6000_5000;
    s0_if.awlen = 8'd3;
    s0_if.wvalid = 1'b1;
    s0_if.wdata = 64'h100;
    s0_if.bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    s0_if.awvalid = 1'b0;
    s0_if.wdata = 64'h101;
    @(negedge clk);
    s0_if.wdata = 64'h102;
    @(negedge clk);
    s0_if.wdata = 64'h103;
    #1;
    checks++;
    if (m_if.wvalid !== 1'b1 ||
        dut.wr_st !== WR_DATA) begin
      errors++;
      $display("FAIL rst_pre: got wv%b st%0d want 1 2",
               m_if.wvalid, dut.wr_st);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (hs_out() !== 15'd0) begin
      errors++;
      $display("FAIL rst_drop: got %h want 0", hs_out());
    end
    clr();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (dut.wr_st !== WR_IDLE ||
        dut.rd_st !== RD_IDLE ||
        hs_out() !== 15'd0) begin
      errors++;
      $display("FAIL rst_after: got st%0d/%0d hs%h",
               dut.wr_st, dut.rd_st, hs_out());
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_single_write();
    test_rr_read();
    test_burst_read();
    test_concurrent();
    test_slverr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_axi_arbiter.md
# mmio_axi_arbiter

- Two-master to one-slave AXI4 arbiter that shares the 32-bit-address SoC MMIO port between the core's MMIO master (S0) and a second on-chip master such as debug or DMA (S1).
- Sits between the core wrapper and the MMIO interconnect.
- Read and write directions are arbitrated independently.
- Each direction allows one outstanding transaction, and its grant is held until that transaction's response completes.

## Interface
- ADDR_W, 32, AXI address width
- DATA_W, 64, AXI data width; STRB_W = DATA_W/8
- ID_W, 5, AXI ID width, identical on all ports
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- S0_AXI_{aw,w,b,ar,r}*  slave  AXI4  core MMIO master side
  - full field set: id, addr, len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], qos[3:0], data, strb, last, resp[1:0], valid/ready
- S1_AXI_{aw,w,b,ar,r}*  slave  AXI4  second master, same field set as S0
- M_AXI_{aw,w,b,ar,r}*  master  AXI4  downstream MMIO port, same field set

## Operation
**Write FSM (WR_IDLE, WR_ADDR, WR_DATA, WR_RESP)**
- WR_IDLE: if any Sx awvalid is high, register `wgrant` from the picker, then go to WR_ADDR.
- WR_ADDR: M aw* carries the granted master's AW. On the M aw handshake, go to WR_DATA.
- WR_DATA: M w* carries the granted master's W. On a handshake with wlast=1, go to WR_RESP.
- WR_RESP: M bready is driven by the granted master's bready. On the B handshake, go to WR_IDLE and update the write last-grant.

**Read FSM (RD_IDLE, RD_ADDR, RD_DATA)**
- Same grant rules as the write FSM.
- RD_DATA forwards R beats to the granted master and returns to RD_IDLE on the handshake with rlast=1.

**Routing and pass-through**
- Each Sx valid/ready of a non-granted master, or in a non-matching state, is held 0.
- IDs, len, size, burst, cache, prot, qos and resp pass through unchanged.
- B and R are routed by the held grant, not by ID. SLVERR and DECERR are passed through.
- W arriving before AW is stalled (wready=0) until WR_DATA. This is AXI-legal.

**Arbitration and boundary cases**
- Round-robin: on simultaneous requests, the master not granted last wins. Last-grant resets to S1, so S0 wins first.
- A master that drops awvalid/arvalid after WR_IDLE/RD_IDLE latched its grant is a protocol violation. The FSM waits in ADDR indefinitely.
- Both directions may be busy at once, for the same or different masters.
- Reset mid-transaction returns both FSMs to IDLE and drops all valid/ready outputs immediately. An abandoned downstream transaction requires a system-wide reset.

## Timing
**Reset values**
- All Sx/M valid and ready outputs are 0.
- FSMs are in IDLE; wgrant=rgrant=S0; last-grants are S1.

**Output drive**
- M payload outputs are a combinational mux of the granted master's fields. They are defined only while the corresponding valid is high.
- Ready/valid paths through the arbiter are combinational within a state. No added register stage per beat.

**Latency**
- Request valid in IDLE → M valid asserted 1 cycle later.
- Write of N beats, with zero-wait slave, costs 1 + 1 + N + 1 cycles; read costs 1 + 1 + N.
- The return to IDLE costs 1 further cycle, so back-to-back same-direction grants are separated by one idle cycle.

## Configuration
- MMIO_ARB_FIXED_PRIO_EN defined: S0 always wins simultaneous requests, and the last-grant registers are removed.
- Undefined (default): round-robin per direction, as described in Operation.

## Structure
**Package `mmio_arb_pkg`**
- `wr_state_t`, `rd_state_t`
- AXI field width constants: LEN_W=8, SIZE_W=3, BURST_W=2, CACHE_W=4, PROT_W=3, QOS_W=4, RESP_W=2
- Master index type.

**Sub-module `mmio_arb_picker`**
- 2-way picker holding the last-grant register and honouring MMIO_ARB_FIXED_PRIO_EN.
- Instantiated once for writes and once for reads.

## Test plan
- S0 single-beat write to 0x6000_0000, data 0x1122334455667788, strb 0xFF → M AW 1 cycle after request, S0 bvalid with OKAY, S1 all readies 0 throughout.
- S0 and S1 raise arvalid in the same cycle (IDs 3 and 7), repeated twice → grants alternate S0, S1, S0, S1. With MMIO_ARB_FIXED_PRIO_EN defined, all go to S0 first.
- S1 4-beat read (arlen=3) with the slave inserting 2-cycle rvalid gaps → all 4 beats reach S1 with rid unchanged; the FSM leaves RD_DATA only on rlast.
- S0 write concurrent with S1 read → both complete without interference. S0 presents W 3 cycles before AW and sees wready=0 until the M aw handshake.
- Slave returns bresp=SLVERR to S1 → S1 receives SLVERR with bid unchanged; S0 is unaffected.
- reset asserted in WR_DATA after beat 2 of 4 → same-cycle drop of M_AXI wvalid and all readies; FSM is in WR_IDLE after reset release.
